// File: rtl/obi_cache_master.sv
// OBI master that pushes key/value commands into a cache register window.
// Optional watchdog compiled in with `define OBI_CACHE_MASTER_TIMEOUT_EN.

package ctrl_types_pkg;
    typedef enum logic [1:0] {
        NOP = 2'd0,
        PUT = 2'd1,
        GET = 2'd2,
        DEL = 2'd3
    } operation_e;
endpackage

package if_types_pkg;
    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int KEY_WIDTH   = 16;
    localparam int VALUE_WIDTH = 2 * DATA_WIDTH;

    typedef struct packed {
        logic                    req;
        logic [ADDR_WIDTH-1:0]   addr;
        logic                    we;
        logic [DATA_WIDTH/8-1:0] be;
        logic [DATA_WIDTH-1:0]   wdata;
        logic                    rready;
    } obi_req_t;

    typedef struct packed {
        logic                  gnt;
        logic                  rvalid;
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } obi_rsp_t;
endpackage

module obi_cache_master #(
    parameter int          ARCHITECTURE   = 32,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  ctrl_types_pkg::operation_e           cmd_op,
    input  logic [if_types_pkg::KEY_WIDTH-1:0]   cmd_key,
    input  logic [if_types_pkg::VALUE_WIDTH-1:0] cmd_value,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [if_types_pkg::VALUE_WIDTH-1:0] res_value,
    output logic                                 res_err,
    output if_types_pkg::obi_req_t               obi_req,
    input  if_types_pkg::obi_rsp_t               obi_resp
);
    import ctrl_types_pkg::*;
    import if_types_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ARCHITECTURE / 8);
    localparam logic [ADDR_WIDTH-1:0] OFF2 = ADDR_WIDTH'(2 * (ARCHITECTURE / 8));
    localparam logic [ADDR_WIDTH-1:0] OFF3 = ADDR_WIDTH'(3 * (ARCHITECTURE / 8));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             beat_q, beat_d;
    operation_e             op_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [VALUE_WIDTH-1:0] val_q;

    logic                   accept;
    logic                   store_lo;
    logic                   store_hi;
    logic                   set_err;
    logic                   rd_beat;
    logic [2:0]             last_beat;
    logic [ADDR_WIDTH-1:0]  beat_off;
    logic [DW-1:0]          beat_wdata;

`ifdef OBI_CACHE_MASTER_TIMEOUT_EN
    logic [31:0] wd_q;
    logic        busy;
    logic        progress;
    logic        tmo_hit;

    assign busy     = (state_q == ADDR) || (state_q == RESP);
    assign progress = ((state_q == ADDR) && obi_resp.gnt) ||
                      ((state_q == RESP) && obi_resp.rvalid);
    assign tmo_hit  = busy && !progress &&
                      (wd_q == 32'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts stalled cycles, cleared on any bus progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if (!busy || progress) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 32'd1;
        end
    end
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = 32'(TIMEOUT_CYCLES);
`endif

    // Per-beat address offset and write data
    always_comb begin
        rd_beat    = (beat_q >= 3'd4);
        last_beat  = (op_q == GET) ? 3'd5 : 3'd3;
        beat_off   = '0;
        beat_wdata = '0;
        unique case (beat_q)
            3'd0: beat_wdata = val_q[DW-1:0];
            3'd1: begin
                beat_off   = STEP;
                beat_wdata = val_q[2*DW-1:DW];
            end
            3'd2: begin
                beat_off   = OFF2;
                beat_wdata = DW'(key_q);
            end
            3'd3: begin
                beat_off   = OFF3;
                beat_wdata = DW'(op_q);
            end
            3'd4: beat_off = '0;
            3'd5: beat_off = STEP;
            default: beat_off = '0;
        endcase
    end

    // Next-state logic and capture strobes
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        accept   = 1'b0;
        store_lo = 1'b0;
        store_hi = 1'b0;
        set_err  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    beat_d  = 3'd0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (obi_resp.gnt) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (obi_resp.rvalid) begin
                    if (obi_resp.err) begin
                        set_err = 1'b1;
                        state_d = DONE;
                    end else begin
                        store_lo = (beat_q == 3'd4);
                        store_hi = (beat_q == 3'd5);
                        if (beat_q == last_beat) begin
                            state_d = DONE;
                        end else begin
                            beat_d  = beat_q + 3'd1;
                            state_d = ADDR;
                        end
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef OBI_CACHE_MASTER_TIMEOUT_EN
        if (tmo_hit) begin
            set_err  = 1'b1;
            store_lo = 1'b0;
            store_hi = 1'b0;
            state_d  = DONE;
        end
`endif
    end

    // State and beat index registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Command capture and result accumulation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= NOP;
            key_q     <= '0;
            val_q     <= '0;
            res_value <= '0;
            res_err   <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= cmd_op;
                key_q     <= cmd_key;
                val_q     <= cmd_value;
                res_value <= '0;
                res_err   <= 1'b0;
            end
            if (store_lo) begin
                res_value[DW-1:0] <= obi_resp.rdata;
            end
            if (store_hi) begin
                res_value[2*DW-1:DW] <= obi_resp.rdata;
            end
            if (set_err) begin
                res_err <= 1'b1;
            end
        end
    end

    // OBI request side: address phase in ADDR, response accept in RESP
    always_comb begin
        obi_req = '0;
        if (state_q == ADDR) begin
            obi_req.req   = 1'b1;
            obi_req.addr  = BASE_ADDR + beat_off;
            obi_req.we    = !rd_beat;
            obi_req.be    = '1;
            obi_req.wdata = rd_beat ? '0 : beat_wdata;
        end
        obi_req.rready = (state_q == RESP);
    end

    assign cmd_ready = (state_q == IDLE);
    assign res_valid = (state_q == DONE);

endmodule

// File: tb/tb_obi_cache_master.sv
// Self-checking bench for obi_cache_master: random commands, OBI slave
// model with stalls/errors, compared against a beat-list reference model.

module tb_obi_cache_master;
    import ctrl_types_pkg::*;
    import if_types_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0100;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    operation_e  cmd_op = NOP;
    logic [15:0] cmd_key = '0;
    logic [63:0] cmd_value = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] res_value;
    logic        res_err;
    obi_req_t    obi_req;
    obi_rsp_t    obi_resp = '0;

    int errors = 0;
    int checks = 0;

    beat_t obs[$];
    beat_t exp_q[$];

    obi_cache_master #(
        .ARCHITECTURE(32),
        .BASE_ADDR(BASE),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_key(cmd_key),
        .cmd_value(cmd_value),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_value(res_value),
        .res_err(res_err),
        .obi_req(obi_req),
        .obi_resp(obi_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    // Reference model: list of bus beats a command should produce
    task automatic model(input operation_e op, input logic [15:0] key,
                         input logic [63:0] val, input int err_beat,
                         input logic [31:0] lo, input logic [31:0] hi,
                         output int nb, output logic [63:0] rv,
                         output logic re);
        exp_q.delete();
        exp_q.push_back('{BASE, 1'b1, 4'hF, val[31:0]});
        exp_q.push_back('{BASE + 32'd4, 1'b1, 4'hF, val[63:32]});
        exp_q.push_back('{BASE + 32'd8, 1'b1, 4'hF, {16'h0, key}});
        exp_q.push_back('{BASE + 32'd12, 1'b1, 4'hF, {30'h0, op}});
        if (op == GET) begin
            exp_q.push_back('{BASE, 1'b0, 4'hF, 32'h0});
            exp_q.push_back('{BASE + 32'd4, 1'b0, 4'hF, 32'h0});
        end
        re = 1'b0;
        if (err_beat >= 0 && err_beat < exp_q.size()) begin
            re = 1'b1;
            while (exp_q.size() > err_beat + 1) void'(exp_q.pop_back());
        end
        nb = exp_q.size();
        rv = (op == GET && !re) ? {hi, lo} : 64'h0;
    endtask

    function automatic int beat_diff();
        int n;
        n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (obs[i].addr !== exp_q[i].addr || obs[i].we !== exp_q[i].we ||
                obs[i].wdata !== exp_q[i].wdata ||
                (exp_q[i].we && obs[i].be !== exp_q[i].be))
                return i;
        end
        if (obs.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // Drive one command and act as the OBI slave until res_valid
    task automatic run_txn(input operation_e op, input logic [15:0] key,
                           input logic [63:0] val, input int stall_beat,
                           input int stall_n, input int err_beat,
                           input logic [31:0] lo, input logic [31:0] hi,
                           input bit noise, output int cycles,
                           output bit unstable, output bit proto_bad,
                           output bit hung);
        beat_t first, cur;
        bit pend, pend_err, have_first, done;
        logic [31:0] pend_rdata;
        int idx, waited;
        obs.delete();
        cycles = 0; unstable = 0; proto_bad = 0; hung = 0;
        pend = 0; pend_err = 0; have_first = 0; done = 0;
        pend_rdata = '0; idx = 0; waited = 0; first = '0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_key = key; cmd_value = val;
        @(posedge clk);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            obi_resp = '0;
            cmd_valid = 1'b0;
            if (res_valid) begin
                done = 1;
                break;
            end
            if (noise) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op = operation_e'($urandom_range(0, 3));
                cmd_key = 16'($urandom);
                cmd_value = {$urandom, $urandom};
            end
            cycles++;
            if (pend) begin
                if (!obi_req.rready || obi_req.req) proto_bad = 1;
                obi_resp.rvalid = 1'b1;
                obi_resp.err = pend_err;
                obi_resp.rdata = pend_rdata;
                pend = 0;
            end else begin
                if (obi_req.rready) proto_bad = 1;
                if (noise) begin
                    obi_resp.rvalid = 1'($urandom_range(0, 1));
                    obi_resp.err = 1'b1;
                    obi_resp.rdata = $urandom;
                end
                if (obi_req.req) begin
                    cur = '{obi_req.addr, obi_req.we, obi_req.be, obi_req.wdata};
                    if (!have_first) begin
                        first = cur;
                        have_first = 1;
                    end else if (cur != first) begin
                        unstable = 1;
                    end
                    if (idx == stall_beat && waited < stall_n) begin
                        waited++;
                    end else begin
                        obi_resp.gnt = 1'b1;
                        obs.push_back(cur);
                        pend = 1;
                        pend_err = (idx == err_beat);
                        if (!cur.we && cur.addr == BASE) pend_rdata = lo;
                        else if (!cur.we && cur.addr == BASE + 32'd4) pend_rdata = hi;
                        else pend_rdata = $urandom;
                        idx++;
                        have_first = 0;
                    end
                end
            end
        end
        obi_resp = '0;
        cmd_valid = 1'b0;
        hung = !done;
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (obi_req.req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b want=0", obi_req.req); end
        checks++; if (obi_req.rready !== 1'b0) begin errors++; $display("FAIL rst_rready got=%b want=0", obi_req.rready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got=%b want=0", res_valid); end
        checks++; if (res_value !== 64'h0) begin errors++; $display("FAIL rst_res_value got=%h want=0", res_value); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL rst_res_err got=%b want=0", res_err); end
        checks++; if (obi_req.addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h want=0", obi_req.addr); end
        checks++; if (obi_req.wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got=%h want=0", obi_req.wdata); end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got=%b want=1", cmd_ready); end
    endtask

    task automatic test_put();
        int cyc, nb, d; bit un, pb, hg; logic [63:0] rv; logic re;
        model(PUT, 16'h0042, 64'h1122334455667788, -1, 32'h0, 32'h0, nb, rv, re);
        run_txn(PUT, 16'h0042, 64'h1122334455667788, -1, 0, -1, 32'h0, 32'h0, 0, cyc, un, pb, hg);
        d = beat_diff();
        checks++; if (hg) begin errors++; $display("FAIL put_done res_valid never seen"); end
        checks++; if (d != -1) begin errors++; $display("FAIL put_beat idx=%0d got=%h want=%h n=%0d/%0d", d, obs[d], exp_q[d], obs.size(), nb); end
        checks++; if (cyc != 8) begin errors++; $display("FAIL put_cycles got=%0d want=8", cyc); end
        checks++; if (res_err !== re || res_value !== rv) begin errors++; $display("FAIL put_result got=%b/%h want=%b/%h", res_err, res_value, re, rv); end
        checks++; if (pb) begin errors++; $display("FAIL put_proto req/rready misuse got=1 want=0"); end
        release_res();
    endtask

    task automatic test_get();
        int cyc, nb, d; bit un, pb, hg; logic [63:0] rv; logic re;
        model(GET, 16'h0042, 64'h0, -1, 32'h55667788, 32'h11223344, nb, rv, re);
        run_txn(GET, 16'h0042, 64'h0, -1, 0, -1, 32'h55667788, 32'h11223344, 0, cyc, un, pb, hg);
        d = beat_diff();
        checks++; if (hg) begin errors++; $display("FAIL get_done res_valid never seen"); end
        checks++; if (d != -1) begin errors++; $display("FAIL get_beat idx=%0d got=%h want=%h n=%0d/%0d", d, obs[d], exp_q[d], obs.size(), nb); end
        checks++; if (cyc != 12) begin errors++; $display("FAIL get_cycles got=%0d want=12", cyc); end
        checks++; if (res_value !== 64'h1122334455667788) begin errors++; $display("FAIL get_value got=%h want=1122334455667788", res_value); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL get_err got=%b want=0", res_err); end
        checks++; if (pb) begin errors++; $display("FAIL get_proto req/rready misuse got=1 want=0"); end
        release_res();
    endtask

    task automatic test_stall();
        int cyc, nb, d; bit un, pb, hg; logic [63:0] rv; logic re;
        model(PUT, 16'hBEEF, 64'hCAFE0000DEAD0001, -1, 32'h0, 32'h0, nb, rv, re);
        run_txn(PUT, 16'hBEEF, 64'hCAFE0000DEAD0001, 2, 5, -1, 32'h0, 32'h0, 0, cyc, un, pb, hg);
        d = beat_diff();
        checks++; if (hg) begin errors++; $display("FAIL stall_done res_valid never seen"); end
        checks++; if (un) begin errors++; $display("FAIL stall_stable addr/wdata changed got=1 want=0"); end
        checks++; if (d != -1) begin errors++; $display("FAIL stall_beat idx=%0d got=%h want=%h", d, obs[d], exp_q[d]); end
        checks++; if (cyc != 13) begin errors++; $display("FAIL stall_cycles got=%0d want=13", cyc); end
        checks++; if (res_err !== 1'b0 || res_value !== 64'h0) begin errors++; $display("FAIL stall_result got=%b/%h want=0/0", res_err, res_value); end
        release_res();
    endtask

    task automatic test_err();
        int cyc, nb, d; bit un, pb, hg; logic [63:0] rv; logic re;
        model(GET, 16'h0007, 64'h0123456789ABCDEF, 3, 32'h1, 32'h2, nb, rv, re);
        run_txn(GET, 16'h0007, 64'h0123456789ABCDEF, -1, 0, 3, 32'h1, 32'h2, 0, cyc, un, pb, hg);
        d = beat_diff();
        checks++; if (hg) begin errors++; $display("FAIL err_done res_valid never seen"); end
        checks++; if (d != -1) begin errors++; $display("FAIL err_beats idx=%0d n=%0d want=%0d", d, obs.size(), nb); end
        checks++; if (cyc != 2 * nb) begin errors++; $display("FAIL err_cycles got=%0d want=%0d", cyc, 2 * nb); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_err !== 1'b1 || res_value !== 64'h0) begin
                errors++;
                $display("FAIL err_hold cyc=%0d got=%b/%b/%h want=1/1/0", i, res_valid, res_err, res_value);
            end
        end
        release_res();
        checks++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL err_release got=%b/%b want=0/1", res_valid, cmd_ready); end
    endtask

    task automatic test_reset_midflight();
        int cyc, nb, d; bit un, pb, hg; logic [63:0] rv; logic re;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = PUT; cmd_key = 16'h1234; cmd_value = 64'hAAAA_BBBB_CCCC_DDDD;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        obi_resp.gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        obi_resp = '0;
        obi_resp.rvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        obi_resp = '0;
        checks++; if (obi_req.req !== 1'b1 || obi_req.addr !== BASE + 32'd4) begin errors++; $display("FAIL mid_beat1 got=%b/%h want=1/%h", obi_req.req, obi_req.addr, BASE + 32'd4); end
        obi_resp.gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        obi_resp = '0;
        checks++; if (obi_req.rready !== 1'b1) begin errors++; $display("FAIL mid_resp rready got=%b want=1", obi_req.rready); end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (obi_req.req !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b1 || obi_req.rready !== 1'b0) begin
            errors++; $display("FAIL mid_reset req/res_valid/cmd_ready/rready got=%b%b%b%b want=0010", obi_req.req, res_valid, cmd_ready, obi_req.rready);
        end
        rst_n = 1'b1;
        obi_resp.rvalid = 1'b1; obi_resp.err = 1'b1; obi_resp.rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        obi_resp = '0;
        checks++; if (cmd_ready !== 1'b1 || obi_req.req !== 1'b0 || res_err !== 1'b0) begin
            errors++; $display("FAIL mid_late_rvalid got=%b/%b/%b want=1/0/0", cmd_ready, obi_req.req, res_err);
        end
        model(PUT, 16'h00AA, 64'h0F0F_F0F0_1234_5678, -1, 32'h0, 32'h0, nb, rv, re);
        run_txn(PUT, 16'h00AA, 64'h0F0F_F0F0_1234_5678, -1, 0, -1, 32'h0, 32'h0, 0, cyc, un, pb, hg);
        d = beat_diff();
        checks++; if (hg || d != -1 || cyc != 8) begin errors++; $display("FAIL mid_after_put hung=%b idx=%0d cyc=%0d want 0/-1/8", hg, d, cyc); end
        release_res();
    endtask

    task automatic test_random();
        int cyc, nb, d, sb, sn, eb, ecyc; bit un, pb, hg, nz;
        logic [63:0] rv, val; logic re; logic [15:0] key;
        logic [31:0] lo, hi; operation_e op;
        for (int it = 0; it < 30; it++) begin
            op  = operation_e'($urandom_range(0, 3));
            key = 16'($urandom);
            val = {$urandom, $urandom};
            lo  = $urandom; hi = $urandom;
            sb  = $urandom_range(0, 5);
            sn  = $urandom_range(0, 4);
            eb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            nz  = 1'($urandom_range(0, 1));
            model(op, key, val, eb, lo, hi, nb, rv, re);
            ecyc = 2 * nb + ((sb < nb) ? sn : 0);
            run_txn(op, key, val, sb, sn, eb, lo, hi, nz, cyc, un, pb, hg);
            d = beat_diff();
            checks++; if (hg) begin errors++; $display("FAIL rnd_done it=%0d res_valid never seen", it); end
            checks++; if (d != -1) begin errors++; $display("FAIL rnd_beat it=%0d idx=%0d got=%h want=%h n=%0d/%0d", it, d, obs[d], exp_q[d], obs.size(), nb); end
            checks++; if (cyc != ecyc) begin errors++; $display("FAIL rnd_cycles it=%0d got=%0d want=%0d", it, cyc, ecyc); end
            checks++; if (res_value !== rv) begin errors++; $display("FAIL rnd_value it=%0d got=%h want=%h", it, res_value, rv); end
            checks++; if (res_err !== re) begin errors++; $display("FAIL rnd_err it=%0d got=%b want=%b", it, res_err, re); end
            checks++; if (pb || un) begin errors++; $display("FAIL rnd_proto it=%0d proto=%b unstable=%b want=0/0", it, pb, un); end
            release_res();
        end
    endtask

    initial begin
        test_reset();
        test_put();
        test_get();
        test_stall();
        test_err();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/obi_cache_master.md
OBI_CACHE_MASTER -- requirements
Module: obi_cache_master

Interface
REQ-001 SHALL have parameter ARCHITECTURE, default 32, OBI address/data width in bits.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0, byte address of the cache interface register window.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, watchdog limit; used only when the watchdog is compiled in.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port cmd_valid  in  1  command offered.
REQ-007 SHALL have port cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-008 SHALL have port cmd_op  in  ctrl_types_pkg::operation_e  requested operation.
REQ-009 SHALL have port cmd_key  in  if_types_pkg::KEY_WIDTH  key.
REQ-010 SHALL have port cmd_value  in  if_types_pkg::VALUE_WIDTH  value, equal to 2*ARCHITECTURE.
REQ-011 SHALL have port res_valid  out  1  result available.
REQ-012 SHALL have port res_ready  in  1  result consumed when res_valid && res_ready.
REQ-013 SHALL have port res_value  out  VALUE_WIDTH  read-back value.
REQ-014 SHALL have port res_err  out  1  operation failed.
REQ-015 SHALL have port obi_req  out  if_types_pkg::obi_req_t  OBI A-channel fields req, addr, we, be, wdata, plus rready.
REQ-016 SHALL have port obi_resp  in  if_types_pkg::obi_rsp_t  OBI fields gnt, rvalid, rdata, err.

Function
REQ-017 SHALL capture cmd_op/key/value into internal registers on command handshake; cmd_ready=1 only in IDLE.
REQ-018 SHALL use states IDLE, ADDR, RESP, DONE; a beat index 0..5 selects the current transfer.
REQ-019 SHALL issue write beats in order: value[31:0]@BASE+0x0, value[63:32]@BASE+0x4, key zero-extended@BASE+0x8, op zero-extended@BASE+0xC; op always written last.
REQ-020 SHALL issue read beats value-low@BASE+0x0, then value-high@BASE+0x4, only when cmd_op==ctrl_types_pkg::GET.
REQ-021 SHALL drive be=all-ones and we=1 on write beats, we=0 and wdata=0 on read beats.
REQ-022 SHALL assert req only in ADDR, holding addr/we/wdata stable until gnt; ADDR->RESP on gnt.
REQ-023 SHALL keep at most one transaction outstanding; req=0 in RESP.
REQ-024 SHALL drive rready=1 in RESP only; on rvalid, read beats store rdata into the matching res_value half.
REQ-025 SHALL, on rvalid with err=0, go RESP->ADDR for the next beat, or RESP->DONE after the last beat.
REQ-026 SHALL, on rvalid with err=1, set res_err=1, skip all remaining beats and go to DONE.
REQ-027 SHALL assert res_valid only in DONE; DONE->IDLE on res_ready, with res_value/res_err held stable until then.
REQ-028 SHALL clear res_value and res_err on each new command accept; non-GET results return res_value=0.
REQ-029 SHALL ignore rvalid arriving outside RESP and ignore cmd_valid outside IDLE.
REQ-030 SHALL take 2 cycles per beat minimum (gnt same cycle as req, rvalid next cycle): 8 cycles for write-only ops, 12 for GET, excluding DONE.

Reset
REQ-031 SHALL, while rst_n=0 at a rising edge, enter IDLE, beat index 0, and drive req=0, rready=0, cmd_ready=1 after reset, res_valid=0, res_value=0, res_err=0, addr=0, wdata=0.
REQ-032 SHALL abandon any in-flight transaction on reset without completing it; a late rvalid after reset is ignored per REQ-029.

Configuration
REQ-033 SHALL compile a watchdog when OBI_CACHE_MASTER_TIMEOUT_EN is defined: a counter resets on every ADDR/RESP entry and on gnt/rvalid; reaching TIMEOUT_CYCLES in ADDR or RESP forces res_err=1, req=0 and DONE.
REQ-034 SHALL, without OBI_CACHE_MASTER_TIMEOUT_EN, contain no counter and wait indefinitely for gnt/rvalid.

Verification
REQ-035 PUT key=0x0042 value=0x1122334455667788, gnt/rvalid immediate -> writes 0x55667788@0x0, 0x11223344@0x4, 0x42@0x8, op@0xC; res_valid after 8 cycles, res_err=0, res_value=0.
REQ-036 GET key=0x0042, reads return 0x55667788 then 0x11223344 -> res_value=0x1122334455667788, res_err=0, 12 cycles.
REQ-037 gnt withheld 5 cycles on beat 2 -> req, addr=0x8, wdata stable all 5 cycles; sequence completes normally.
REQ-038 err=1 on op-word response -> res_err=1, no read beats issued even for GET, res_valid held until res_ready pulses after 3 cycles.
REQ-039 rst_n=0 during RESP of beat 1 -> next cycle IDLE, req=0, res_valid=0; subsequent PUT completes correctly.
REQ-040 With OBI_CACHE_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, gnt never asserted -> DONE with res_err=1 after 16 cycles in ADDR.
